// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670 VGA RGB565 output-bus emulator with test patterns
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_BLANK       = 288,
  parameter int unsigned V_SYNC_LINES  = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL    = V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES;
  localparam int unsigned V_ACT0     = V_SYNC_LINES + V_BACK_LINES;
  localparam int unsigned HW         = $clog2(LINE_BYTES);
  localparam int unsigned VW         = $clog2(V_TOTAL);
  localparam int unsigned BAR_PX     = H_ACTIVE / 8;
  localparam int unsigned BPW        = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic [BPW-1:0]  bar_px;
  logic [2:0]      bar_idx;
  logic [1:0]      frame_mode;
  logic [15:0]     frame_solid;

  logic            last_h;
  logic            last_v;
  logic            in_hact;
  logic            in_vact;
  logic            active;
  logic            chk_x;
  logic            chk_y;
  logic [7:0]      ramp_v;
  logic [15:0]     bar_color;
  logic [15:0]     pixel;

  assign last_h  = (hcnt == HW'(LINE_BYTES - 1));
  assign last_v  = (vcnt == VW'(V_TOTAL - 1));
  assign in_hact = (32'(hcnt) < 2 * H_ACTIVE);
  assign in_vact = (32'(vcnt) >= V_ACT0) && (32'(vcnt) < V_ACT0 + V_ACTIVE);
  assign active  = in_hact && in_vact;
  assign ramp_v  = 8'(hcnt >> 1);
  assign chk_x   = ((32'(hcnt) >> 1) & 32'd8) != 32'd0;
  assign chk_y   = ((32'(vcnt) - V_ACT0) & 32'd8) != 32'd0;

  // Colour of the current bar, indexed by the per-line bar counter
  always_comb begin
    bar_color = 16'h0000;
    case (bar_idx)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      3'd7: bar_color = 16'h0000;
      default: bar_color = 16'h0000;
    endcase
  end

  // RGB565 value of the pixel addressed by the current byte slot
  always_comb begin
    pixel = 16'h0000;
    case (frame_mode)
      2'd0: pixel = bar_color;
      2'd1: pixel = {ramp_v[7:3], ramp_v[7:2], ramp_v[7:3]};
      2'd2: pixel = (chk_x ^ chk_y) ? 16'hFFFF : 16'h0000;
      2'd3: pixel = frame_solid;
      default: pixel = 16'h0000;
    endcase
  end

  // Pixel clock toggle, frame FSM, raster counters and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk        <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'h00;
      state       <= IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      bar_px      <= '0;
      bar_idx     <= 3'd0;
      frame_mode  <= 2'd0;
      frame_solid <= 16'h0000;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      if (pclk) begin
        case (state)
          IDLE: begin
            vsync <= 1'b0;
            href  <= 1'b0;
            d     <= 8'h00;
            busy  <= 1'b0;
            if (en) begin
              state       <= RUN;
              hcnt        <= '0;
              vcnt        <= '0;
              bar_px      <= '0;
              bar_idx     <= 3'd0;
              frame_mode  <= mode;
              frame_solid <= solid_color;
            end
          end
          RUN: begin
            busy  <= 1'b1;
            vsync <= (32'(vcnt) < V_SYNC_LINES);
            href  <= active;
            d     <= active ? (hcnt[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
            // Bar position advances after the low byte of each active pixel
            if (in_hact && hcnt[0]) begin
              if (bar_px == BPW'(BAR_PX - 1)) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_px <= bar_px + BPW'(1);
              end
            end
            if (last_h) begin
              hcnt    <= '0;
              bar_px  <= '0;
              bar_idx <= 3'd0;
              if (last_v) begin
                vcnt       <= '0;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                if (en) begin
                  frame_mode  <= mode;
                  frame_solid <= solid_color;
                end else begin
                  state <= IDLE;
                end
              end else begin
                vcnt <= vcnt + VW'(1);
              end
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
